// File: rtl/ps2kb_command_sequencer.sv
// rtl/ps2kb_command_sequencer.sv - PS/2 host-to-keyboard command sequencer (keyboard reset / LED update)
// Optional post-reset BAT completion check: define PS2KB_CMD_BAT_CHECK_EN.
module ps2kb_command_sequencer #(
  parameter logic [15:0] INHIBIT_CYCLES = 16'd2000,
  parameter logic [19:0] TIMEOUT_CYCLES = 20'd50000,
  parameter logic [1:0]  MAX_RETRY      = 2'd2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       device_clock,
  input  logic       device_data,
  output logic       device_clock_oe,
  output logic       device_data_oe,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  input  logic       kbreset_req,
  input  logic       led_req,
  input  logic [2:0] led_value,
  output logic       busy,
  output logic       rx_divert,
  output logic       done,
  output logic       error
);
  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_RTS, S_TX_BITS, S_TX_LINEACK, S_WAIT_ACK, S_WAIT_BAT, S_DONE
  } state_t;

  localparam logic [23:0] TMO_LOAD = {4'd0, TIMEOUT_CYCLES} - 24'd1;
  localparam logic [23:0] BAT_LOAD = {4'd0, TIMEOUT_CYCLES} * 24'd10 - 24'd1;
  localparam logic [15:0] INH_LOAD = INHIBIT_CYCLES - 16'd1;

  state_t      state;
  logic [1:0]  clk_sync, dat_sync;
  logic        clk_prev;
  logic        kb_pend, led_pend;
  logic [2:0]  led_reg;
  logic [7:0]  tx_byte, next_byte;
  logic        has_next;
  logic [3:0]  bit_cnt;
  logic [1:0]  retry_cnt;
  logic [15:0] inh_cnt;
  logic [23:0] tmo_cnt;
  logic        clk_fall, clk_edge, reply_seen, tmo_active, tmo_hit, fail;

  // Any device clock edge or reply counts as activity and holds off the timeout.
  always_comb begin
    clk_fall   = clk_prev & ~clk_sync[1];
    clk_edge   = clk_prev ^ clk_sync[1];
    reply_seen = rx_valid && (state == S_WAIT_ACK || state == S_WAIT_BAT);
    tmo_active = state inside {S_RTS, S_TX_BITS, S_TX_LINEACK, S_WAIT_ACK, S_WAIT_BAT};
    tmo_hit    = tmo_active && (tmo_cnt == 24'd0) && !clk_edge && !reply_seen;
    fail       = (tmo_hit && state != S_WAIT_BAT)
              || (state == S_TX_LINEACK && clk_fall && dat_sync[1])
              || (state == S_WAIT_ACK && rx_valid && rx_data != 8'hFA);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state           <= S_IDLE;
      clk_sync        <= 2'b11;
      dat_sync        <= 2'b11;
      clk_prev        <= 1'b1;
      kb_pend         <= 1'b0;
      led_pend        <= 1'b0;
      led_reg         <= 3'd0;
      tx_byte         <= 8'd0;
      next_byte       <= 8'd0;
      has_next        <= 1'b0;
      bit_cnt         <= 4'd0;
      retry_cnt       <= 2'd0;
      inh_cnt         <= 16'd0;
      tmo_cnt         <= 24'd0;
      device_clock_oe <= 1'b0;
      device_data_oe  <= 1'b0;
      busy            <= 1'b0;
      rx_divert       <= 1'b0;
      done            <= 1'b0;
      error           <= 1'b0;
    end else begin
      clk_sync <= {clk_sync[0], device_clock};
      dat_sync <= {dat_sync[0], device_data};
      clk_prev <= clk_sync[1];
      done     <= 1'b0;
      error    <= 1'b0;
      if (clk_edge)
        tmo_cnt <= (state == S_WAIT_BAT) ? BAT_LOAD : TMO_LOAD;
      else if (tmo_cnt != 24'd0)
        tmo_cnt <= tmo_cnt - 24'd1;

      case (state)
        S_IDLE: begin
          if (kb_pend || led_pend) begin
            if (kb_pend) begin
              kb_pend  <= 1'b0;
              tx_byte  <= 8'hFF;
              has_next <= 1'b0;
            end else begin
              led_pend  <= 1'b0;
              tx_byte   <= 8'hED;
              next_byte <= {5'b0, led_reg};
              has_next  <= 1'b1;
            end
            retry_cnt       <= 2'd0;
            inh_cnt         <= INH_LOAD;
            device_clock_oe <= 1'b1;
            device_data_oe  <= 1'b0;
            busy            <= 1'b1;
            rx_divert       <= 1'b1;
            state           <= S_INHIBIT;
          end
        end
        S_INHIBIT: begin
          if (inh_cnt == 16'd0) begin
            device_clock_oe <= 1'b0;
            device_data_oe  <= 1'b1;
            tmo_cnt         <= TMO_LOAD;
            state           <= S_RTS;
          end else begin
            inh_cnt <= inh_cnt - 16'd1;
          end
        end
        S_RTS: begin
          if (clk_fall) begin
            device_data_oe <= ~tx_byte[0];
            bit_cnt        <= 4'd1;
            tmo_cnt        <= TMO_LOAD;
            state          <= S_TX_BITS;
          end
        end
        S_TX_BITS: begin
          if (clk_fall) begin
            if (bit_cnt < 4'd8) begin
              device_data_oe <= ~tx_byte[bit_cnt[2:0]];
            end else if (bit_cnt == 4'd8) begin
              device_data_oe <= ^tx_byte;  // line carries odd parity ~^tx_byte
            end else begin
              device_data_oe <= 1'b0;
              tmo_cnt        <= TMO_LOAD;
              state          <= S_TX_LINEACK;
            end
            if (bit_cnt != 4'hF)
              bit_cnt <= bit_cnt + 4'd1;
          end
        end
        S_TX_LINEACK: begin
          if (clk_fall && !dat_sync[1]) begin
            tmo_cnt <= TMO_LOAD;
            state   <= S_WAIT_ACK;
          end
        end
        S_WAIT_ACK: begin
          if (rx_valid && rx_data == 8'hFA) begin
`ifdef PS2KB_CMD_BAT_CHECK_EN
            if (tx_byte == 8'hFF) begin
              tmo_cnt <= BAT_LOAD;
              state   <= S_WAIT_BAT;
            end else
`endif
            if (has_next) begin
              tx_byte         <= next_byte;
              has_next        <= 1'b0;
              retry_cnt       <= 2'd0;
              inh_cnt         <= INH_LOAD;
              device_clock_oe <= 1'b1;
              state           <= S_INHIBIT;
            end else begin
              done  <= 1'b1;
              state <= S_DONE;
            end
          end
        end
`ifdef PS2KB_CMD_BAT_CHECK_EN
        S_WAIT_BAT: begin
          if (rx_valid && rx_data == 8'hAA) begin
            done  <= 1'b1;
            state <= S_DONE;
          end else if ((rx_valid && rx_data == 8'hFC) || tmo_hit) begin
            error     <= 1'b1;
            busy      <= 1'b0;
            rx_divert <= 1'b0;
            state     <= S_IDLE;
          end
        end
`endif
        S_DONE: begin
          busy      <= 1'b0;
          rx_divert <= 1'b0;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      // Retry the same byte from INHIBIT, or give up once the budget is spent.
      if (fail) begin
        if (retry_cnt < MAX_RETRY) begin
          retry_cnt       <= retry_cnt + 2'd1;
          inh_cnt         <= INH_LOAD;
          device_clock_oe <= 1'b1;
          device_data_oe  <= 1'b0;
          state           <= S_INHIBIT;
        end else begin
          error           <= 1'b1;
          busy            <= 1'b0;
          rx_divert       <= 1'b0;
          device_clock_oe <= 1'b0;
          device_data_oe  <= 1'b0;
          state           <= S_IDLE;
        end
      end

      if (kbreset_req)
        kb_pend <= 1'b1;
      if (led_req) begin
        led_pend <= 1'b1;
        led_reg  <= led_value;
      end
    end
  end
endmodule
